// File: rtl/stream_demux_1x2.sv
// Registered 1:2 stream demultiplexer with valid/ready on every side.
// Steering is by sel or by a ping-pong pointer; each output has a one-word holding register.
module stream_demux_1x2 #(
  parameter int NBITS = 8,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_data,
  input  logic             sel,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [NBITS-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [NBITS-1:0] b_data,
  output logic [CNTW-1:0]  cnt_a,
  output logic [CNTW-1:0]  cnt_b
);

  localparam logic [CNTW-1:0] CntOne = 1;

  logic       ptrReg;
  logic       target;
  logic       accept;
  logic [1:0] chReady;
  logic [1:0] chValid;
  logic [1:0] chLoad;

  assign chReady = {b_ready, a_ready};
  assign target  = mode ? ptrReg : sel;

  // in_ready looks only at the targeted channel, never at in_valid
  assign in_ready = rst_n & (target ? (~chValid[1] | b_ready) : (~chValid[0] | a_ready));
  assign accept   = in_valid & in_ready;
  assign chLoad   = {accept & target, accept & ~target};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptrReg <= 1'b0;
    end else if (accept && mode) begin
      ptrReg <= ~ptrReg;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : gCh
    logic             validReg;
    logic [NBITS-1:0] dataReg;
    logic [CNTW-1:0]  cntReg;
    logic             drain;

    assign drain = validReg & chReady[gi];

    // A load in the same cycle as a drain keeps the register full
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        validReg <= 1'b0;
        dataReg  <= '0;
        cntReg   <= '0;
      end else begin
        if (chLoad[gi]) begin
          validReg <= 1'b1;
          dataReg  <= in_data;
        end else if (drain) begin
          validReg <= 1'b0;
        end
        if (drain) begin
          cntReg <= cntReg + CntOne;
        end
      end
    end
  end

  assign chValid = {gCh[1].validReg, gCh[0].validReg};

  assign a_valid = gCh[0].validReg;
  assign a_data  = gCh[0].dataReg;
  assign cnt_a   = gCh[0].cntReg;
  assign b_valid = gCh[1].validReg;
  assign b_data  = gCh[1].dataReg;
  assign cnt_b   = gCh[1].cntReg;

endmodule

// File: tb/tb_stream_demux_1x2.sv
// Directed bench for stream_demux_1x2: a vector table for steady-state behaviour
// plus hand sequences for reset-in-flight, counter wrap and pointer hold.
module tb_stream_demux_1x2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       sel;
  logic       a_valid;
  logic       a_ready;
  logic [7:0] a_data;
  logic       b_valid;
  logic       b_ready;
  logic [7:0] b_data;
  logic [3:0] cnt_a;
  logic [3:0] cnt_b;

  int checks = 0;
  int errors = 0;

  stream_demux_1x2 #(.NBITS(8), .CNTW(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .sel(sel),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rstN, mode, inValid, sel, aReady, bReady;
    logic [7:0] data;
    logic       expIr, expAv, expBv;
    logic [7:0] expAd, expBd;
    logic [3:0] expCa, expCb;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic r, input logic m, input logic v, input logic [7:0] d,
                        input logic s, input logic ar, input logic br,
                        input logic ir, input logic av, input logic [7:0] ad,
                        input logic bv, input logic [7:0] bd,
                        input logic [3:0] ca, input logic [3:0] cb);
    vec_t t;
    t.rstN = r; t.mode = m; t.inValid = v; t.data = d; t.sel = s;
    t.aReady = ar; t.bReady = br;
    t.expIr = ir; t.expAv = av; t.expAd = ad; t.expBv = bv; t.expBd = bd;
    t.expCa = ca; t.expCb = cb;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic m, input logic v, input logic [7:0] d,
                       input logic s, input logic ar, input logic br);
    rst_n = r; mode = m; in_valid = v; in_data = d; sel = s; a_ready = ar; b_ready = br;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Upstream hold rule: a stalled word must keep in_valid, in_data, sel and mode
  logic       prevStall = 1'b0;
  logic [7:0] prevData;
  logic       prevSel, prevMode;
  always @(negedge clk) begin
    if (prevStall && rst_n === 1'b1 &&
        (in_valid !== 1'b1 || in_data !== prevData || sel !== prevSel || mode !== prevMode)) begin
      errors++;
      $display("FAIL upstream hold: in_data 0x%0h sel %0b mode %0b changed from 0x%0h %0b %0b",
               in_data, sel, mode, prevData, prevSel, prevMode);
    end
    prevStall = (rst_n === 1'b1) && (in_valid === 1'b1) && (in_ready !== 1'b1);
    prevData  = in_data;
    prevSel   = sel;
    prevMode  = mode;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //      rst m v data  s ar br | ir av ad   bv bd   ca cb
    addVec(0, 0, 0, 8'h00, 0, 0, 0,  0, 0, 8'h00, 0, 8'h00, 0, 0);
    addVec(1, 0, 1, 8'h11, 0, 1, 0,  1, 0, 8'h00, 0, 8'h00, 0, 0);
    addVec(1, 0, 0, 8'h00, 0, 1, 0,  1, 1, 8'h11, 0, 8'h00, 0, 0);
    addVec(1, 0, 0, 8'h00, 0, 1, 0,  1, 0, 8'h11, 0, 8'h00, 1, 0);
    addVec(1, 0, 1, 8'h01, 1, 1, 0,  1, 0, 8'h11, 0, 8'h00, 1, 0);
    addVec(1, 0, 1, 8'h02, 1, 1, 0,  0, 0, 8'h11, 1, 8'h01, 1, 0);
    addVec(1, 0, 1, 8'h02, 1, 1, 0,  0, 0, 8'h11, 1, 8'h01, 1, 0);
    addVec(1, 0, 1, 8'h02, 1, 1, 1,  1, 0, 8'h11, 1, 8'h01, 1, 0);
    addVec(1, 0, 1, 8'h03, 1, 1, 1,  1, 0, 8'h11, 1, 8'h02, 1, 1);
    addVec(1, 0, 1, 8'h04, 1, 1, 1,  1, 0, 8'h11, 1, 8'h03, 1, 2);
    addVec(1, 0, 0, 8'h00, 1, 1, 1,  1, 0, 8'h11, 1, 8'h04, 1, 3);
    addVec(1, 0, 0, 8'h00, 1, 1, 1,  1, 0, 8'h11, 0, 8'h04, 1, 4);
    addVec(1, 1, 1, 8'hA0, 0, 1, 1,  1, 0, 8'h11, 0, 8'h04, 1, 4);
    addVec(1, 1, 1, 8'hA1, 0, 1, 1,  1, 1, 8'hA0, 0, 8'h04, 1, 4);
    addVec(1, 1, 1, 8'hA2, 0, 1, 1,  1, 0, 8'hA0, 1, 8'hA1, 2, 4);
    addVec(1, 1, 1, 8'hA3, 0, 1, 1,  1, 1, 8'hA2, 0, 8'hA1, 2, 5);
    addVec(1, 1, 1, 8'hA4, 0, 1, 1,  1, 0, 8'hA2, 1, 8'hA3, 3, 5);
    addVec(1, 1, 1, 8'hA5, 0, 1, 1,  1, 1, 8'hA4, 0, 8'hA3, 3, 6);
    addVec(1, 1, 0, 8'h00, 0, 1, 1,  1, 0, 8'hA4, 1, 8'hA5, 4, 6);
    addVec(1, 1, 0, 8'h00, 0, 1, 1,  1, 0, 8'hA4, 0, 8'hA5, 4, 7);
    addVec(1, 0, 1, 8'h33, 0, 0, 1,  1, 0, 8'hA4, 0, 8'hA5, 4, 7);
    addVec(1, 0, 1, 8'h5C, 1, 0, 1,  1, 1, 8'h33, 0, 8'hA5, 4, 7);
    addVec(1, 0, 0, 8'h00, 1, 0, 0,  0, 1, 8'h33, 1, 8'h5C, 4, 7);
    addVec(1, 0, 0, 8'h00, 0, 0, 0,  0, 1, 8'h33, 1, 8'h5C, 4, 7);

    drive(0, 0, 0, 8'h00, 0, 0, 0);
    nextCycle();
    nextCycle();

    foreach (vecs[i]) begin
      drive(vecs[i].rstN, vecs[i].mode, vecs[i].inValid, vecs[i].data,
            vecs[i].sel, vecs[i].aReady, vecs[i].bReady);
      @(negedge clk);
      $display("vec %0d: in_ready=%0b a=%0b/%02h b=%0b/%02h cnt_a=%0d cnt_b=%0d",
               i, in_ready, a_valid, a_data, b_valid, b_data, cnt_a, cnt_b);
      chk($sformatf("v%0d in_ready", i), in_ready, vecs[i].expIr);
      chk($sformatf("v%0d a_valid", i),  a_valid,  vecs[i].expAv);
      chk($sformatf("v%0d a_data", i),   a_data,   vecs[i].expAd);
      chk($sformatf("v%0d b_valid", i),  b_valid,  vecs[i].expBv);
      chk($sformatf("v%0d b_data", i),   b_data,   vecs[i].expBd);
      chk($sformatf("v%0d cnt_a", i),    cnt_a,    vecs[i].expCa);
      chk($sformatf("v%0d cnt_b", i),    cnt_b,    vecs[i].expCb);
      nextCycle();
    end

    // Reset while both channels hold words and a word is stalled upstream
    drive(1, 0, 1, 8'h77, 0, 0, 0);
    @(negedge clk); chk("rst stall in_ready", in_ready, 0);
    nextCycle();
    drive(0, 0, 1, 8'h77, 0, 0, 0);
    @(negedge clk); chk("rst low in_ready", in_ready, 0);
    nextCycle();
    drive(1, 1, 1, 8'h9E, 0, 0, 0);
    @(negedge clk);
    $display("post-reset: a=%0b/%02h b=%0b/%02h cnt_a=%0d cnt_b=%0d",
             a_valid, a_data, b_valid, b_data, cnt_a, cnt_b);
    chk("post-rst a_valid", a_valid, 0);
    chk("post-rst a_data", a_data, 8'h00);
    chk("post-rst b_valid", b_valid, 0);
    chk("post-rst b_data", b_data, 8'h00);
    chk("post-rst cnt_a", cnt_a, 0);
    chk("post-rst cnt_b", cnt_b, 0);
    chk("post-rst in_ready", in_ready, 1);
    nextCycle();
    drive(1, 1, 0, 8'h00, 0, 0, 0);
    @(negedge clk);
    chk("post-rst first word a_valid", a_valid, 1);
    chk("post-rst first word a_data", a_data, 8'h9E);
    chk("post-rst first word b_valid", b_valid, 0);
    nextCycle();

    // 17 A handshakes with a 4-bit counter
    drive(0, 0, 0, 8'h00, 0, 0, 0);
    nextCycle();
    for (int k = 1; k <= 17; k++) begin
      drive(1, 0, 1, 8'(k), 0, 1, 0);
      @(negedge clk);
      chk($sformatf("wrap word %0d in_ready", k), in_ready, 1);
      nextCycle();
    end
    drive(1, 0, 0, 8'h00, 0, 1, 0);
    @(negedge clk);
    chk("wrap last a_valid", a_valid, 1);
    chk("wrap last a_data", a_data, 8'h11);
    chk("wrap cnt_a at 16", cnt_a, 0);
    nextCycle();
    @(negedge clk);
    $display("wrap: cnt_a=%0d a_valid=%0b", cnt_a, a_valid);
    chk("wrap cnt_a at 17", cnt_a, 1);
    chk("wrap drained a_valid", a_valid, 0);
    nextCycle();

    // Pointer held at B across a mode 0 stretch
    drive(1, 1, 1, 8'hC1, 0, 1, 1);
    @(negedge clk); chk("pp C1 in_ready", in_ready, 1);
    nextCycle();
    drive(1, 0, 1, 8'hC2, 0, 1, 1);
    @(negedge clk); chk("pp C1 a_data", a_data, 8'hC1); chk("pp C1 a_valid", a_valid, 1);
    nextCycle();
    drive(1, 1, 1, 8'hC3, 0, 1, 1);
    @(negedge clk);
    chk("pp C2 a_data", a_data, 8'hC2); chk("pp C3 in_ready", in_ready, 1);
    chk("pp pre-C3 b_valid", b_valid, 0);
    nextCycle();
    drive(1, 1, 1, 8'hC4, 0, 1, 1);
    @(negedge clk);
    chk("pp C3 b_valid", b_valid, 1); chk("pp C3 b_data", b_data, 8'hC3);
    chk("pp C3 a_valid", a_valid, 0);
    nextCycle();
    drive(1, 1, 0, 8'h00, 0, 1, 1);
    @(negedge clk);
    $display("ping-pong: a=%0b/%02h b=%0b/%02h cnt_a=%0d cnt_b=%0d",
             a_valid, a_data, b_valid, b_data, cnt_a, cnt_b);
    chk("pp C4 a_valid", a_valid, 1); chk("pp C4 a_data", a_data, 8'hC4);
    chk("pp C4 b_valid", b_valid, 0);
    chk("pp cnt_a", cnt_a, 3); chk("pp cnt_b", cnt_b, 1);
    nextCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
